// File: rtl/addr_map_rule_pkg.sv
// ---------------------------------------------------------------------------
// addr_map_rule_pkg
// Purpose : Shared address-map rule type used by the testharness interconnect
//           pieces. A rule maps the half-open byte range
//           [start_addr, end_addr) onto the port number held in idx.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package addr_map_rule_pkg;

   typedef struct packed {
      logic [31:0] idx;
      logic [31:0] start_addr;
      logic [31:0] end_addr;
   } addr_map_rule_t;

endpackage

// File: rtl/ext_periph_obi_demux_pkg.sv
// ---------------------------------------------------------------------------
// ext_periph_obi_demux_pkg
// Purpose : Constants and types for the external-peripheral OBI demux:
//           decode-error read data, the testharness external-peripheral rule
//           table and the port-index width helper.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package ext_periph_obi_demux_pkg;

   import addr_map_rule_pkg::*;

   localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;

   localparam logic [31:0] EXT_PERIPHERAL_START_ADDRESS = 32'h3000_0000;

   localparam int unsigned EXT_NSLAVES = 4;

   typedef addr_map_rule_t [EXT_NSLAVES-1:0] ext_rule_array_t;

   // memcopy, AMS, IFFIFO and simple accelerator windows; every end is exclusive.
   // The AMS window is deliberately short so that base+0x1100 decodes as a miss.
   localparam ext_rule_array_t EXT_PERIPH_RULES = '{
      0: '{idx: 32'd0,
           start_addr: EXT_PERIPHERAL_START_ADDRESS + 32'h0000_0000,
           end_addr:   EXT_PERIPHERAL_START_ADDRESS + 32'h0000_1000},
      1: '{idx: 32'd1,
           start_addr: EXT_PERIPHERAL_START_ADDRESS + 32'h0000_1000,
           end_addr:   EXT_PERIPHERAL_START_ADDRESS + 32'h0000_1100},
      2: '{idx: 32'd2,
           start_addr: EXT_PERIPHERAL_START_ADDRESS + 32'h0000_2000,
           end_addr:   EXT_PERIPHERAL_START_ADDRESS + 32'h0000_3000},
      3: '{idx: 32'd3,
           start_addr: EXT_PERIPHERAL_START_ADDRESS + 32'h0000_3000,
           end_addr:   EXT_PERIPHERAL_START_ADDRESS + 32'h0000_4000}
   };

   // Port indices must also encode the virtual error port (value NSlaves).
   function automatic int unsigned port_idx_width(input int unsigned n_slaves);
      return $clog2(n_slaves + 1);
   endfunction

endpackage

// File: rtl/ext_periph_addr_match.sv
// ---------------------------------------------------------------------------
// ext_periph_addr_match
// Purpose : Combinational first-match address decoder over a rule table.
//           Rule 0 has the highest priority. A miss returns NRules.
// Ports   : i_addr  - byte address to decode
//           o_sel   - idx field of the first matching rule, or NRules on miss
//           o_miss  - no rule matched
// ---------------------------------------------------------------------------
module ext_periph_addr_match
   import addr_map_rule_pkg::*;
#(
   parameter int unsigned NRules = 4,
   parameter int unsigned PortW  = 3,
   parameter addr_map_rule_t [NRules-1:0] Rules = '0
) (
   input  logic [31:0]      i_addr,
   output logic [PortW-1:0] o_sel,
   output logic             o_miss
);

   // Walk the rules from last to first so that the lowest-numbered match
   // is the one left standing.
   always_comb begin
      o_sel  = PortW'(NRules);
      o_miss = 1'b1;
      for (int i = int'(NRules) - 1; i >= 0; i--) begin
         if ((i_addr >= Rules[i].start_addr) && (i_addr < Rules[i].end_addr)) begin
            o_sel  = Rules[i].idx[PortW-1:0];
            o_miss = 1'b0;
         end
      end
   end

endmodule

// File: rtl/ext_periph_obi_demux.sv
// ---------------------------------------------------------------------------
// ext_periph_obi_demux
// Purpose : Splits the MCU external-peripheral OBI request stream over
//           NSlaves peripherals by address, answers unmapped addresses with
//           an internal error responder, and returns responses in order.
// Ports   : clk_i, rst_i            - clock, synchronous active-high reset
//           mst_*                   - OBI responder side toward the MCU
//           slv_req_o/slv_gnt_i     - one-hot request / per-slave grants
//           slv_addr/we/be/wdata_o  - broadcast request fields
//           slv_rvalid_i/rdata_i    - per-slave responses (slave k at [32k+:32])
//           spurious_rsp_o          - unexpected slave rvalid seen this cycle
//           busy_o                  - transactions outstanding
// ---------------------------------------------------------------------------
module ext_periph_obi_demux
   import addr_map_rule_pkg::*;
   import ext_periph_obi_demux_pkg::*;
#(
   parameter int unsigned NSlaves  = EXT_NSLAVES,
   parameter int unsigned MaxTrans = 2,
   parameter addr_map_rule_t [NSlaves-1:0] AddrRules = EXT_PERIPH_RULES,
   parameter logic [31:0] ErrRdata = ERR_RDATA
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  mst_req_i,
   input  logic [31:0]           mst_addr_i,
   input  logic                  mst_we_i,
   input  logic [3:0]            mst_be_i,
   input  logic [31:0]           mst_wdata_i,
   output logic                  mst_gnt_o,
   output logic                  mst_rvalid_o,
   output logic [31:0]           mst_rdata_o,
   output logic                  mst_err_o,
   output logic [NSlaves-1:0]    slv_req_o,
   output logic [31:0]           slv_addr_o,
   output logic                  slv_we_o,
   output logic [3:0]            slv_be_o,
   output logic [31:0]           slv_wdata_o,
   input  logic [NSlaves-1:0]    slv_gnt_i,
   input  logic [NSlaves-1:0]    slv_rvalid_i,
   input  logic [NSlaves*32-1:0] slv_rdata_i,
   output logic                  spurious_rsp_o,
   output logic                  busy_o
);

   localparam int unsigned       PortW   = port_idx_width(NSlaves);
   localparam int unsigned       CntW    = $clog2(MaxTrans + 1);
   localparam logic [PortW-1:0]  ErrPort = PortW'(NSlaves);
   localparam logic [CntW-1:0]   CntMax  = CntW'(MaxTrans);

   logic [CntW-1:0]    cnt_q;
   logic [PortW-1:0]   cur_port_q;
   logic               err_pend_q;

   logic [PortW-1:0]   w_sel;
   logic               w_miss;
   logic               w_isErr;
   logic [PortW-1:0]   w_port;
   logic               w_busy;
   logic               w_stall;
   logic               w_fwd;
   logic               w_slvGnt;
   logic               w_curRvalid;
   logic [31:0]        w_curRdata;
   logic               w_slvRoute;
   logic [NSlaves-1:0] w_expMask;
   logic               w_accept;

   ext_periph_addr_match #(
      .NRules (NSlaves),
      .PortW  (PortW),
      .Rules  (AddrRules)
   ) u_match (
      .i_addr (mst_addr_i),
      .o_sel  (w_sel),
      .o_miss (w_miss)
   );

   // A rule pointing past the last slave is treated like a miss so the
   // error responder catches it instead of indexing a missing port.
   assign w_isErr = w_miss || (w_sel >= ErrPort);
   assign w_port  = w_isErr ? ErrPort : w_sel;

   assign w_busy  = (cnt_q != '0);
   // Switching ports only after a full drain keeps responses in order.
   assign w_stall = (cnt_q == CntMax) || (w_busy && (w_port != cur_port_q));
   assign w_fwd   = !rst_i && !w_stall;

   assign w_slvRoute = w_busy && (cur_port_q < ErrPort);

   always_comb begin
      w_slvGnt    = 1'b0;
      w_curRvalid = 1'b0;
      w_curRdata  = '0;
      w_expMask   = '0;
      slv_req_o   = '0;
      for (int k = 0; k < int'(NSlaves); k++) begin
         if (w_port == PortW'(k)) begin
            w_slvGnt     = slv_gnt_i[k];
            slv_req_o[k] = w_fwd && !w_isErr && mst_req_i;
         end
         if (cur_port_q == PortW'(k)) begin
            w_curRvalid  = slv_rvalid_i[k];
            w_curRdata   = slv_rdata_i[32*k +: 32];
            w_expMask[k] = w_busy;
         end
      end
   end

   assign mst_gnt_o = w_fwd && (w_isErr ? mst_req_i : w_slvGnt);
   assign w_accept  = mst_req_i && mst_gnt_o;

   // The error responder answers exactly one cycle after its grant; otherwise
   // the response comes from the port that owns the outstanding transactions.
   always_comb begin
      mst_rvalid_o = 1'b0;
      mst_err_o    = 1'b0;
      mst_rdata_o  = '0;
      if (!rst_i) begin
         if (err_pend_q) begin
            mst_rvalid_o = 1'b1;
            mst_err_o    = 1'b1;
            mst_rdata_o  = ErrRdata;
         end else if (w_slvRoute) begin
            mst_rvalid_o = w_curRvalid;
            mst_rdata_o  = w_curRdata;
         end
      end
   end

   assign spurious_rsp_o = !rst_i && (|(slv_rvalid_i & ~w_expMask));
   assign busy_o         = !rst_i && w_busy;

   assign slv_addr_o  = mst_addr_i;
   assign slv_we_o    = mst_we_i;
   assign slv_be_o    = mst_be_i;
   assign slv_wdata_o = mst_wdata_i;

   // Outstanding-transaction bookkeeping; a grant and a response in the same
   // cycle cancel out.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q      <= '0;
         cur_port_q <= '0;
         err_pend_q <= 1'b0;
      end else begin
         if (w_accept && !mst_rvalid_o) begin
            cnt_q <= cnt_q + CntW'(1);
         end else if (!w_accept && mst_rvalid_o) begin
            cnt_q <= cnt_q - CntW'(1);
         end
         if (w_accept) begin
            cur_port_q <= w_port;
         end
         err_pend_q <= w_accept && w_isErr;
      end
   end

endmodule

// File: tb/tb_ext_periph_obi_demux.sv
// ---------------------------------------------------------------------------
// tb_ext_periph_obi_demux
// Purpose : Self-checking bench for ext_periph_obi_demux. A transaction-level
//           model (queue of outstanding transactions plus a queue of scheduled
//           slave responses) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_ext_periph_obi_demux;

   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam int          MAXT = 2;
   localparam logic [31:0] ERRV = 32'hBADACCE5;

   logic         clk_i;
   logic         rst_i;
   logic         mst_req_i;
   logic [31:0]  mst_addr_i;
   logic         mst_we_i;
   logic [3:0]   mst_be_i;
   logic [31:0]  mst_wdata_i;
   logic         mst_gnt_o;
   logic         mst_rvalid_o;
   logic [31:0]  mst_rdata_o;
   logic         mst_err_o;
   logic [3:0]   slv_req_o;
   logic [31:0]  slv_addr_o;
   logic         slv_we_o;
   logic [3:0]   slv_be_o;
   logic [31:0]  slv_wdata_o;
   logic [3:0]   slv_gnt_i;
   logic [3:0]   slv_rvalid_i;
   logic [127:0] slv_rdata_i;
   logic         spurious_rsp_o;
   logic         busy_o;

   ext_periph_obi_demux dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .mst_req_i      (mst_req_i),
      .mst_addr_i     (mst_addr_i),
      .mst_we_i       (mst_we_i),
      .mst_be_i       (mst_be_i),
      .mst_wdata_i    (mst_wdata_i),
      .mst_gnt_o      (mst_gnt_o),
      .mst_rvalid_o   (mst_rvalid_o),
      .mst_rdata_o    (mst_rdata_o),
      .mst_err_o      (mst_err_o),
      .slv_req_o      (slv_req_o),
      .slv_addr_o     (slv_addr_o),
      .slv_we_o       (slv_we_o),
      .slv_be_o       (slv_be_o),
      .slv_wdata_o    (slv_wdata_o),
      .slv_gnt_i      (slv_gnt_i),
      .slv_rvalid_i   (slv_rvalid_i),
      .slv_rdata_i    (slv_rdata_i),
      .spurious_rsp_o (spurious_rsp_o),
      .busy_o         (busy_o)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   typedef struct {
      int port;
      int due;
   } txn_t;

   typedef struct {
      int          due;
      logic [31:0] data;
   } rsp_t;

   txn_t        outQ[$];
   rsp_t        sched[$];
   int          cyc;
   int          curPort;
   int          checks;
   int          failures;
   logic        doReset;
   logic        mReq;
   logic        mWe;
   logic [31:0] mAddr;
   bit          gntAll;
   bit          randSpur;
   int          dMin;
   int          dMax;
   int          forceSpur;
   bit          lastAccept;

   logic [31:0] addrPool [14];

   // Counts one comparison and reports it when the values differ.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s cycle=%0d observed=0x%08h expected=0x%08h",
                  tag, cyc, observed, expected);
      end
   endtask

   // Address windows written as offsets from the external-peripheral base.
   function automatic int decodeAddr(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - BASE;
      if (off < 32'h1000)                          return 0;
      if (off >= 32'h1000 && off < 32'h1100)       return 1;
      if (off >= 32'h2000 && off < 32'h3000)       return 2;
      if (off >= 32'h3000 && off < 32'h4000)       return 3;
      return 4;
   endfunction

   // One clock cycle: drive inputs after the edge, predict and compare before
   // the next edge, then advance the transaction-level model.
   task automatic applyStimulus();
      int          sel;
      int          cnt;
      int          k;
      int          due;
      bit          slvRsp;
      logic        expStall;
      logic        expGnt;
      logic        expRvalid;
      logic        expErr;
      logic        expSpur;
      logic        expBusy;
      logic [3:0]  expReq;
      logic [31:0] expRdata;
      logic [3:0]  rv;

      @(posedge clk_i);
      #1;
      rst_i       = doReset;
      mst_req_i   = mReq;
      mst_addr_i  = mAddr;
      mst_we_i    = mWe;
      mst_be_i    = 4'($urandom);
      mst_wdata_i = $urandom;
      slv_gnt_i   = gntAll ? 4'hF : 4'($urandom);
      for (int j = 0; j < 4; j++) slv_rdata_i[32*j +: 32] = $urandom;

      cnt    = outQ.size();
      rv     = '0;
      slvRsp = 1'b0;
      if (!doReset && cnt != 0 && curPort < 4 && sched.size() != 0 && sched[0].due <= cyc) begin
         rv[curPort]                = 1'b1;
         slv_rdata_i[curPort*32 +: 32] = sched[0].data;
         slvRsp                     = 1'b1;
      end
      k = -1;
      if (forceSpur >= 0) k = forceSpur;
      else if (randSpur && ($urandom % 16 == 0)) k = int'($urandom % 4);
      if (k >= 0 && (cnt == 0 || k != curPort)) rv[k] = 1'b1;
      slv_rvalid_i = rv;

      #1;
      expGnt    = 1'b0;
      expReq    = '0;
      expRvalid = 1'b0;
      expErr    = 1'b0;
      expRdata  = '0;
      expSpur   = 1'b0;
      expBusy   = 1'b0;
      sel       = decodeAddr(mAddr);
      if (!doReset) begin
         expStall = (cnt == MAXT) || (cnt != 0 && sel != curPort);
         if (!expStall && sel < 4 && mReq) expReq = 4'(1 << sel);
         if (!expStall) expGnt = (sel == 4) ? mReq : slv_gnt_i[sel];
         if (cnt != 0 && curPort < 4) begin
            expRvalid = rv[curPort];
            expRdata  = slv_rdata_i[curPort*32 +: 32];
         end else if (cnt != 0 && curPort == 4 && outQ[0].due == cyc) begin
            expRvalid = 1'b1;
            expErr    = 1'b1;
            expRdata  = ERRV;
         end
         for (int j = 0; j < 4; j++) begin
            if (rv[j] && (cnt == 0 || j != curPort)) expSpur = 1'b1;
         end
         expBusy = (cnt != 0);
      end

      checkOutput("gnt",    32'(mst_gnt_o),      32'(expGnt));
      checkOutput("slvreq", 32'(slv_req_o),      32'(expReq));
      checkOutput("rvalid", 32'(mst_rvalid_o),   32'(expRvalid));
      checkOutput("err",    32'(mst_err_o),      32'(expErr));
      checkOutput("rdata",  mst_rdata_o,         expRdata);
      checkOutput("spur",   32'(spurious_rsp_o), 32'(expSpur));
      checkOutput("busy",   32'(busy_o),         32'(expBusy));
      if (!doReset) checkOutput("slvaddr", slv_addr_o, mAddr);

      lastAccept = 1'b0;
      if (doReset) begin
         outQ.delete();
         sched.delete();
         curPort = 0;
      end else begin
         if (expRvalid) begin
            void'(outQ.pop_front());
            if (slvRsp) void'(sched.pop_front());
         end
         if (mReq && expGnt) begin
            lastAccept = 1'b1;
            outQ.push_back('{port: sel, due: cyc + 1});
            curPort = sel;
            if (sel < 4) begin
               due = cyc + int'($urandom_range(dMax, dMin));
               if (sched.size() != 0 && sched[$].due >= due) due = sched[$].due + 1;
               sched.push_back('{due: due, data: $urandom});
            end
         end
      end
      cyc++;
   endtask

   initial begin
      int n;
      checks    = 0;
      failures  = 0;
      cyc       = 0;
      curPort   = 0;
      doReset   = 1'b1;
      mReq      = 1'b0;
      mWe       = 1'b0;
      mAddr     = '0;
      gntAll    = 1'b1;
      randSpur  = 1'b0;
      dMin      = 3;
      dMax      = 3;
      forceSpur = -1;
      rst_i        = 1'b1;
      mst_req_i    = 1'b0;
      mst_addr_i   = '0;
      mst_we_i     = 1'b0;
      mst_be_i     = '0;
      mst_wdata_i  = '0;
      slv_gnt_i    = '0;
      slv_rvalid_i = '0;
      slv_rdata_i  = '0;

      addrPool = '{BASE + 32'h0, BASE + 32'h4, BASE + 32'hFFC, BASE + 32'h1000,
                   BASE + 32'h10FC, BASE + 32'h1100, BASE + 32'h1800, BASE + 32'h2000,
                   BASE + 32'h2FFC, BASE + 32'h3000, BASE + 32'h3010, BASE + 32'h3FFC,
                   BASE + 32'h4000, BASE - 32'h4};

      // Reset state.
      repeat (2) applyStimulus();
      doReset = 1'b0;
      applyStimulus();

      // Single read to slave0 answered three cycles after the grant.
      $display("[TB] read to slave0");
      mReq = 1'b1; mAddr = BASE + 32'h4;
      applyStimulus();
      mReq = 1'b0;
      repeat (5) applyStimulus();

      // Write to the accelerator, then an AMS read that must wait for the drain.
      $display("[TB] port switch waits for drain");
      mReq = 1'b1; mWe = 1'b1; mAddr = BASE + 32'h3010;
      applyStimulus();
      mWe = 1'b0; mAddr = BASE + 32'h1000;
      n = 0;
      for (int i = 0; i < 20 && n == 0; i++) begin
         applyStimulus();
         if (lastAccept) n = 1;
      end
      if (n == 0) checkOutput("switch_timeout", 32'd0, 32'd1);
      mReq = 1'b0;
      repeat (6) applyStimulus();

      // Exclusive end of the AMS window goes to the error responder.
      $display("[TB] decode error at AMS end");
      mReq = 1'b1; mAddr = BASE + 32'h1100;
      applyStimulus();
      mReq = 1'b0;
      repeat (3) applyStimulus();

      // Back-to-back reads limited by the outstanding-transaction ceiling.
      $display("[TB] back-to-back reads to slave2");
      dMin = 4; dMax = 4;
      mReq = 1'b1; mAddr = BASE + 32'h2000;
      n = 0;
      for (int i = 0; i < 30 && n < 3; i++) begin
         applyStimulus();
         if (lastAccept) n++;
      end
      if (n < 3) checkOutput("b2b_timeout", 32'(n), 32'd3);
      mReq = 1'b0;
      repeat (8) applyStimulus();

      // Response from slave1 with nothing outstanding.
      $display("[TB] spurious response while idle");
      forceSpur = 1;
      applyStimulus();
      forceSpur = -1;
      repeat (2) applyStimulus();

      // Reset with two reads in flight to slave0; a late response is spurious.
      $display("[TB] reset mid-operation");
      dMin = 10; dMax = 10;
      mReq = 1'b1; mAddr = BASE + 32'h0;
      n = 0;
      for (int i = 0; i < 10 && n < 2; i++) begin
         applyStimulus();
         if (lastAccept) n++;
      end
      if (n < 2) checkOutput("rst_fill_timeout", 32'(n), 32'd2);
      mReq = 1'b0;
      doReset = 1'b1;
      applyStimulus();
      doReset = 1'b0;
      applyStimulus();
      forceSpur = 0;
      applyStimulus();
      forceSpur = -1;
      applyStimulus();

      // Randomized traffic with random grants, latencies, spurious pulses and resets.
      $display("[TB] random traffic");
      gntAll = 1'b0; randSpur = 1'b1; dMin = 1; dMax = 5;
      for (int i = 0; i < 3000; i++) begin
         doReset = ($urandom % 96 == 0);
         mReq    = ($urandom % 4 != 0);
         mWe     = 1'($urandom);
         mAddr   = ($urandom % 10 == 0) ? 32'($urandom) : addrPool[$urandom % 14];
         applyStimulus();
      end
      doReset = 1'b0; mReq = 1'b0; randSpur = 1'b0; gntAll = 1'b1;
      repeat (12) applyStimulus();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
